// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered digits.
// Ports: clk, reset (async, high), enable, number/dp_in/load in;
//   ledBCD, dp_out, Anodeselect (registered), digit_idx, frame_done out.
// Optional macro LEADING_ZERO_BLANK_EN turns on leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS       = 8,
  parameter int DIV_WIDTH        = 17,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       number,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  output logic [3:0]                    ledBCD,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         Anodeselect,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [DIV_WIDTH-1:0]    r_presc;
  logic [IW-1:0]           r_digit;
  logic [4*NUM_DIGITS-1:0] r_act_num;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_num;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_vld;
  logic [3:0]              r_led;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_tick;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_sel;

  assign w_tick   = enable && (r_presc == {DIV_WIDTH{1'b1}});
  assign w_wrap   = w_tick && (r_digit == LAST);
  assign w_onehot = NUM_DIGITS'(1) << r_digit;

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] w_msnz;
  logic          w_blank;

  // Highest nonzero nibble; digits above it are dark unless their dp is on.
  always_comb begin
    w_msnz = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (r_act_num[4*k +: 4] != 4'h0) w_msnz = IW'(k);
    end
    w_blank = (r_digit > w_msnz) && !r_act_dp[r_digit];
  end

  assign w_sel = w_blank ? '0 : w_onehot;
`else
  assign w_sel = w_onehot;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (enable) begin
      r_presc <= r_presc + 1'b1;
      if (w_tick) r_digit <= (r_digit == LAST) ? '0 : r_digit + 1'b1;
    end
  end

  // A load coinciding with the wrap bypasses the pending buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_num  <= '0;
      r_act_dp   <= '0;
      r_pend_num <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
    end else if (load && w_wrap) begin
      r_act_num  <= number;
      r_act_dp   <= dp_in;
      r_pend_vld <= 1'b0;
    end else if (load) begin
      r_pend_num <= number;
      r_pend_dp  <= dp_in;
      r_pend_vld <= 1'b1;
    end else if (w_wrap && r_pend_vld) begin
      r_act_num  <= r_pend_num;
      r_act_dp   <= r_pend_dp;
      r_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= 4'h0;
      r_dp  <= 1'b0;
      r_an  <= AN_OFF;
    end else if (enable) begin
      r_led <= r_act_num[{r_digit, 2'b00} +: 4];
      r_dp  <= r_act_dp[r_digit];
      r_an  <= ANODE_ACTIVE_LOW ? ~w_sel : w_sel;
    end else begin
      r_an  <= AN_OFF;
    end
  end

  assign ledBCD      = r_led;
  assign dp_out      = r_dp;
  assign Anodeselect = r_an;
  assign digit_idx   = r_digit;
  assign frame_done  = w_wrap;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 4-clock prescaler).
// Table vectors, directed corner sequences and random traffic vs a model.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] number;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  ledBCD;
  logic        dp_out;
  logic [3:0]  Anodeselect;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .DIV_WIDTH(2),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .number(number),
    .dp_in(dp_in),
    .load(load),
    .ledBCD(ledBCD),
    .dp_out(dp_out),
    .Anodeselect(Anodeselect),
    .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: cnt counts enabled clock edges since reset; the digit shown is
  // (cnt / 4) % 4 and a frame ends on the edge taking cnt%16 from 15.
  int          cnt;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_actdp, m_penddp;
  bit          m_pv;
  logic [3:0]  m_an, m_led;
  logic        m_dp;
  logic        fd_seen;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit blanked(input int d);
    bit b;
    int ms;
    b = 0;
`ifdef LEADING_ZERO_BLANK_EN
    ms = 0;
    for (int k = 0; k < 4; k++)
      if (((m_act >> (4 * k)) & 16'hF) != 0) ms = k;
    b = (d > ms) && !m_actdp[d];
`else
    ms = d;
`endif
    return b;
  endfunction

  task automatic model_reset();
    cnt = 0;
    m_act = 0; m_pend = 0; m_actdp = 0; m_penddp = 0; m_pv = 0;
    m_an = 4'hF; m_led = 0; m_dp = 0;
  endtask

  // Called at a negedge: drive, check frame_done, advance one clock, check.
  task automatic step(input logic en, input logic ld,
                      input logic [15:0] num, input logic [3:0] dp);
    int  d;
    bit  wrap;
    enable = en; load = ld; number = num; dp_in = dp;
    #1;
    d = (cnt / 4) % 4;
    wrap = en && (cnt % 16 == 15);
    fd_seen = frame_done;
    chk("frame_done", {31'b0, frame_done}, {31'b0, wrap});
    if (en) begin
      m_an  = blanked(d) ? 4'hF : ~(4'b1 << d);
      m_led = 4'((m_act >> (4 * d)) & 16'hF);
      m_dp  = m_actdp[d];
    end else begin
      m_an = 4'hF;
    end
    if (ld && wrap) begin
      m_act = num; m_actdp = dp; m_pv = 0;
    end else if (ld) begin
      m_pend = num; m_penddp = dp; m_pv = 1;
    end else if (wrap && m_pv) begin
      m_act = m_pend; m_actdp = m_penddp; m_pv = 0;
    end
    if (en) cnt++;
    @(posedge clk);
    @(negedge clk);
    chk("digit_idx", {30'b0, digit_idx}, 32'((cnt / 4) % 4));
    chk("Anodeselect", {28'b0, Anodeselect}, {28'b0, m_an});
    chk("ledBCD", {28'b0, ledBCD}, {28'b0, m_led});
    chk("dp_out", {31'b0, dp_out}, {31'b0, m_dp});
  endtask

  typedef struct {
    logic [1:0] digit;
    logic [3:0] an;
    logic       fd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{2'd0, 4'hE, 1'b0}; tbl[1]  = '{2'd0, 4'hE, 1'b0};
    tbl[2]  = '{2'd0, 4'hE, 1'b0}; tbl[3]  = '{2'd1, 4'hE, 1'b0};
    tbl[4]  = '{2'd1, 4'hD, 1'b0}; tbl[5]  = '{2'd1, 4'hD, 1'b0};
    tbl[6]  = '{2'd1, 4'hD, 1'b0}; tbl[7]  = '{2'd2, 4'hD, 1'b0};
    tbl[8]  = '{2'd2, 4'hB, 1'b0}; tbl[9]  = '{2'd2, 4'hB, 1'b0};
    tbl[10] = '{2'd2, 4'hB, 1'b0}; tbl[11] = '{2'd3, 4'hB, 1'b0};
    tbl[12] = '{2'd3, 4'h7, 1'b0}; tbl[13] = '{2'd3, 4'h7, 1'b0};
    tbl[14] = '{2'd3, 4'h7, 1'b0}; tbl[15] = '{2'd0, 4'h7, 1'b1};

    reset = 1'b1; enable = 0; load = 0; number = 0; dp_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_an", {28'b0, Anodeselect}, 32'hF);
    chk("rst_led", {28'b0, ledBCD}, 32'h0);
    chk("rst_digit", {30'b0, digit_idx}, 32'h0);
    chk("rst_fd", {31'b0, frame_done}, 32'h0);
    reset = 1'b0;

    // Basic scan; dp on everywhere so no digit can be blanked.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'hF);
      chk("tbl_digit", {30'b0, digit_idx}, {30'b0, tbl[i].digit});
      chk("tbl_an", {28'b0, Anodeselect}, {28'b0, tbl[i].an});
      chk("tbl_fd", {31'b0, fd_seen}, {31'b0, tbl[i].fd});
    end

    // Mid-frame load: nothing shown until the wrap.
    repeat (5) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h1234, 4'h0);
    repeat (3) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      chk("preload_led", {28'b0, ledBCD}, 32'h0);
    end
    while (cnt % 16 != 0) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("load_d0", {28'b0, ledBCD}, 32'h4);
    repeat (16) step(1'b1, 1'b0, 16'h0, 4'h0);

    // Load exactly on the wrap, then a second load for the next frame.
    while (cnt % 16 != 15) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'hABCD, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("wrapload_d0", {28'b0, ledBCD}, 32'hD);
    step(1'b1, 1'b1, 16'h5678, 4'h0);
    repeat (30) step(1'b1, 1'b0, 16'h0, 4'h0);

    // Pause at digit 2.
    while (cnt % 16 != 9) step(1'b1, 1'b0, 16'h0, 4'h0);
    repeat (10) begin
      step(1'b0, 1'b0, 16'h0, 4'h0);
      chk("pause_an", {28'b0, Anodeselect}, 32'hF);
    end
    repeat (12) step(1'b1, 1'b0, 16'h0, 4'h0);

    // Leading-zero pattern, without then with dp on digit 3.
    while (cnt % 16 != 15) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h0050, 4'h0);
    repeat (16) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h0050, 4'h8);
    repeat (32) step(1'b1, 1'b0, 16'h0, 4'h0);

    // Asynchronous reset at digit 3 with a pending load.
    step(1'b1, 1'b1, 16'h9999, 4'hF);
    while (cnt % 16 != 13) step(1'b1, 1'b0, 16'h0, 4'h0);
    #2 reset = 1'b1;
    #1;
    chk("arst_an", {28'b0, Anodeselect}, 32'hF);
    chk("arst_led", {28'b0, ledBCD}, 32'h0);
    chk("arst_dp", {31'b0, dp_out}, 32'h0);
    chk("arst_digit", {30'b0, digit_idx}, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) step(1'b1, 1'b0, 16'h0, 4'hF);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
           16'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits; legal range 2..16.
REQ-002 The block SHALL have parameter DIV_WIDTH, default 17, giving the prescaler width; one scan tick every 2^DIV_WIDTH clocks; legal range 1..24.
REQ-003 The block SHALL have parameter ANODE_ACTIVE_LOW, default 1; 1 means a selected anode is driven 0, 0 means it is driven 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: scan run; when low, all digits are off.
REQ-007 The block SHALL have port number, input, 4*NUM_DIGITS bits: BCD/hex nibbles; nibble k drives digit k.
REQ-008 The block SHALL have port dp_in, input, NUM_DIGITS bits: decimal point request per digit.
REQ-009 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures number and dp_in into the pending buffer.
REQ-010 The block SHALL have port ledBCD, output, 4 bits: nibble of the currently selected digit, registered.
REQ-011 The block SHALL have port dp_out, output, 1 bit: decimal point of the selected digit, registered, active-high.
REQ-012 The block SHALL have port Anodeselect, output, NUM_DIGITS bits: one-hot digit select in ANODE_ACTIVE_LOW polarity, registered.
REQ-013 The block SHALL have port digit_idx, output, $clog2(NUM_DIGITS) bits: index of the digit currently displayed.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-clock pulse when the scan wraps from the last digit to digit 0.

Function
REQ-015 Prescaler: free-running DIV_WIDTH-bit counter, incremented every clock while enable=1; tick asserts in the cycle the count equals all-ones, then the count wraps to 0.
REQ-016 Digit counter: advances by 1 on tick; on tick at NUM_DIGITS-1 it wraps to 0 and frame_done pulses in that same cycle.
REQ-017 Double buffering: load=1 copies number/dp_in into pending and sets pending_valid; the active buffer updates only at the frame wrap, and only if pending_valid=1; pending_valid then clears.
REQ-018 Simultaneous load and wrap: the active buffer SHALL take the incoming number/dp_in directly in that cycle, and pending_valid SHALL end cleared.
REQ-019 Repeated loads before a wrap: the last one wins; earlier values are never displayed.
REQ-020 Output latency: ledBCD, dp_out and Anodeselect SHALL reflect digit_idx and the active buffer one clock after digit_idx changes.
REQ-021 Exactly one anode SHALL be asserted while enable=1, except for digits blanked under REQ-027.
REQ-022 enable=0: the prescaler and digit counter hold; Anodeselect goes all-deasserted on the next clock; ledBCD and dp_out hold; load still functions.
REQ-023 Deasserting and then reasserting enable SHALL resume scanning from the held digit_idx and prescaler count.

Reset
REQ-024 Asserting reset SHALL immediately clear the prescaler, digit_idx, the active and pending buffers, pending_valid, ledBCD, dp_out and frame_done to 0, and set Anodeselect to all-deasserted.
REQ-025 Reset asserted mid-frame SHALL discard the pending data; after release, scanning SHALL restart at digit 0 with a full prescaler period before the first tick.

Configuration
REQ-026 The macro LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-027 With LEADING_ZERO_BLANK_EN defined: in the active buffer, any digit above the most-significant nonzero nibble whose dp bit is 0 SHALL keep its anode deasserted during its slot; digit 0 is always shown, and slot timing is unchanged.
REQ-028 Without LEADING_ZERO_BLANK_EN: all digits SHALL be shown, with no blanking logic present.

Verification
REQ-029 Scan with NUM_DIGITS=4, DIV_WIDTH=2 and enable=1 after reset -> ticks every 4 clocks; Anodeselect cycles 1110,1101,1011,0111; frame_done pulses every 16 clocks.
REQ-030 load with number=16'h1234 mid-frame -> ledBCD stays 0 until the wrap; the following frame shows 4,3,2,1 on digits 0..3.
REQ-031 load with 16'hABCD in the wrap cycle, then load with 16'h5678 -> the next frame shows D,C,B,A; the frame after shows 8,7,6,5.
REQ-032 enable dropped for 10 clocks at digit 2 -> Anodeselect=1111; after re-enable the scan resumes at digit 2 with the remaining prescaler count.
REQ-033 LEADING_ZERO_BLANK_EN defined, number=16'h0050 -> digits 2 and 3 are dark; digit 0 shows 0 and digit 1 shows 5; with dp_in[3]=1, digit 3 lights showing 0.
REQ-034 Reset pulsed at digit 3 with pending_valid=1 -> all outputs return to reset values at once; the pending data is never displayed.
